uart_ram_sequencer: RTL and testbench

Controller that sequences the host link around the decode datapath. In the load phase it packs UART receive bytes into 32-bit words and writes them to the encoded-word RAM. In the dump phase it reads the 8-bit decoded-pixel RAM and streams each byte out through the UART transmitter. It sits between `uart_rx_t`/`uart_tx_t` and the two single-port RAMs. It replaces the ad-hoc byte shifting that was previously inlined in the top level.

---
 rtl/seq_pkg.sv | 17 +
 rtl/byte_packer.sv | 39 +++
 rtl/uart_ram_sequencer.sv | 108 ++++++++++
 tb/tb_uart_ram_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and lane constants for the UART/RAM sequencer
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOAD_DONE,
    DUMP_RD,
    DUMP_WAIT,
    DUMP_TX,
    DUMP_DONE
  } state_t;

  localparam int LANE_MSB       = 3;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - MSB-first 4-to-1 byte assembler with a registered word strobe
module byte_packer
  import seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [7:0]  byte_data,
  output logic [1:0]  lane,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [(BYTES_PER_WORD-1)*8-1:0] shreg;

  // Shift the first three bytes in; the fourth completes the word, which then
  // holds until the next completed word so a new byte 0 can arrive meanwhile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane       <= '0;
      shreg      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (push) begin
        if (lane == 2'(LANE_MSB)) begin
          word       <= {shreg, byte_data};
          word_valid <= 1'b1;
          lane       <= '0;
        end else begin
          shreg <= {shreg[(BYTES_PER_WORD-2)*8-1:0], byte_data};
          lane  <= lane + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_ram_sequencer.sv
// rtl/uart_ram_sequencer.sv - loads packed UART bytes into RAM, then dumps RAM bytes to UART
module uart_ram_sequencer
  import seq_pkg::*;
#(
  parameter int LOAD_WORDS = 2405,
  parameter int LOAD_AW    = 12,
  parameter int DUMP_BYTES = 76800,
  parameter int DUMP_AW    = 17
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_en_i,
  input  logic               dump_en_i,
  input  logic               rx_done_i,
  input  logic [7:0]         rx_byte_i,
  output logic               load_we_o,
  output logic [LOAD_AW-1:0] load_addr_o,
  output logic [31:0]        load_data_o,
  output logic               load_done_o,
  output logic               dump_en_o,
  output logic [DUMP_AW-1:0] dump_addr_o,
  input  logic [7:0]         dump_data_i,
  output logic               tx_start_o,
  output logic [7:0]         tx_byte_o,
  input  logic               tx_done_i,
  output logic               dump_done_o,
  output logic               busy_o
);

  localparam logic [LOAD_AW-1:0] LAST_WORD = LOAD_AW'(LOAD_WORDS - 1);
  localparam logic [DUMP_AW-1:0] LAST_BYTE = DUMP_AW'(DUMP_BYTES - 1);

  state_t             state_q, state_d;
  logic [LOAD_AW-1:0] word_cnt;
  logic [LOAD_AW-1:0] addr_q;
  logic [DUMP_AW-1:0] byte_cnt;
  logic [7:0]         tx_byte_q;
  logic               push;
  logic               word_fire;
  logic [1:0]         lane;
  logic               word_valid;
  logic [31:0]        word;

  assign push      = (state_q == LOAD) && load_en_i && rx_done_i;
  assign word_fire = push && (lane == 2'(LANE_MSB));

  byte_packer u_packer (
    .clk        (clk_i),
    .rst        (rst_i),
    .push       (push),
    .byte_data  (rx_byte_i),
    .lane       (lane),
    .word_valid (word_valid),
    .word       (word)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: load beats dump in IDLE; the load ends once the last word's write pulse is out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (load_en_i) state_d = LOAD;
                 else if (dump_en_i) state_d = DUMP_RD;
      LOAD:      if (word_valid && addr_q == LAST_WORD) state_d = LOAD_DONE;
      LOAD_DONE: if (dump_en_i) state_d = DUMP_RD;
      DUMP_RD:   if (dump_en_i) state_d = DUMP_WAIT;
      DUMP_WAIT: state_d = DUMP_TX;
      DUMP_TX:   if (tx_done_i) state_d = (byte_cnt == LAST_BYTE) ? DUMP_DONE : DUMP_RD;
      DUMP_DONE: state_d = DUMP_DONE;
      default:   state_d = IDLE;
    endcase
  end

  // Word/byte counters saturate at their last index; the write address is latched as the word completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_cnt  <= '0;
      addr_q    <= '0;
      byte_cnt  <= '0;
      tx_byte_q <= '0;
    end else begin
      if (word_fire) begin
        addr_q <= word_cnt;
        if (word_cnt != LAST_WORD) word_cnt <= word_cnt + 1'b1;
      end
      if (state_q == DUMP_WAIT) tx_byte_q <= dump_data_i;
      if (state_q == DUMP_TX && tx_done_i && byte_cnt != LAST_BYTE)
        byte_cnt <= byte_cnt + 1'b1;
    end
  end

  assign load_we_o   = word_valid;
  assign load_addr_o = addr_q;
  assign load_data_o = word;
  assign load_done_o = (state_q == LOAD_DONE);
  assign dump_en_o   = (state_q == DUMP_RD) && dump_en_i;
  assign dump_addr_o = byte_cnt;
  assign tx_start_o  = (state_q == DUMP_TX);
  assign tx_byte_o   = tx_byte_q;
  assign dump_done_o = (state_q == DUMP_DONE);
  assign busy_o      = !(state_q == IDLE || state_q == LOAD_DONE || state_q == DUMP_DONE);

endmodule

// File: tb/tb_uart_ram_sequencer.sv
// tb/tb_uart_ram_sequencer.sv - randomized self-checking bench with a behavioural load/dump model
module tb_uart_ram_sequencer;

  localparam int LW  = 2;
  localparam int LAW = 4;
  localparam int DB  = 3;
  localparam int DAW = 4;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic           load_en_i = 1'b0;
  logic           dump_en_i = 1'b0;
  logic           rx_done_i = 1'b0;
  logic [7:0]     rx_byte_i = 8'h00;
  logic           load_we_o;
  logic [LAW-1:0] load_addr_o;
  logic [31:0]    load_data_o;
  logic           load_done_o;
  logic           dump_en_o;
  logic [DAW-1:0] dump_addr_o;
  logic [7:0]     dump_data_i = 8'h00;
  logic           tx_start_o;
  logic [7:0]     tx_byte_o;
  logic           tx_done_i = 1'b0;
  logic           dump_done_o;
  logic           busy_o;

  uart_ram_sequencer #(
    .LOAD_WORDS (LW),
    .LOAD_AW    (LAW),
    .DUMP_BYTES (DB),
    .DUMP_AW    (DAW)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_en_i   (load_en_i),
    .dump_en_i   (dump_en_i),
    .rx_done_i   (rx_done_i),
    .rx_byte_i   (rx_byte_i),
    .load_we_o   (load_we_o),
    .load_addr_o (load_addr_o),
    .load_data_o (load_data_o),
    .load_done_o (load_done_o),
    .dump_en_o   (dump_en_o),
    .dump_addr_o (dump_addr_o),
    .dump_data_i (dump_data_i),
    .tx_start_o  (tx_start_o),
    .tx_byte_o   (tx_byte_o),
    .tx_done_i   (tx_done_i),
    .dump_done_o (dump_done_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;
  int phase = 0;
  int cyc = 0;
  logic [7:0]  ram [DB];
  logic [7:0]  acc [$];
  int          n_acc = 0;
  logic [31:0] exp_words [$];
  int          nwr = 0;
  int          ntx = 0;
  logic [31:0] wr_data [$];
  int          wr_addr [$];
  logic [7:0]  tx_log [$];
  int          last_den = -100;
  int          last_done = -100;
  logic        prev_start = 1'b0;
  bit          rand_delay = 1'b1;
  bit          spur = 1'b0;
  int          tx_delay = 10;
  int          cur_delay = 0;
  int          tx_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decoded RAM: one-cycle read latency.
  always @(posedge clk_i)
    if (dump_en_o) dump_data_i <= (int'(dump_addr_o) < DB) ? ram[dump_addr_o[1:0]] : 8'h00;

  // UART transmitter: acknowledges a start after a delay, and throws in stray done strobes when idle.
  initial forever begin
    @(posedge clk_i); #1;
    tx_done_i = 1'b0;
    if (rst_i) tx_cnt = 0;
    else if (tx_start_o) begin
      if (tx_cnt >= cur_delay) begin
        tx_done_i = 1'b1;
        tx_cnt = 0;
      end else tx_cnt++;
    end else begin
      tx_cnt = 0;
      cur_delay = rand_delay ? int'($urandom_range(0, 6)) : tx_delay;
      if (spur && $urandom_range(0, 7) == 0) tx_done_i = 1'b1;
    end
  end

  // Compare process: checks every observable output against the model each cycle.
  always @(negedge clk_i) begin
    cyc++;
    if (!rst_i) begin
      if (phase == 1) begin
        chk("dump_en_in_load", dump_en_o, 0);
        chk("load_done", load_done_o, nwr == LW);
        chk("busy_load", busy_o, nwr != LW);
      end
      if (phase == 2) begin
        chk("busy_dump", busy_o, ntx != DB);
        chk("dump_done", dump_done_o, ntx == DB);
        chk("load_we_in_dump", load_we_o, 0);
        if (ntx == DB) chk("tx_start_after_done", tx_start_o, 0);
      end
      if (load_we_o) begin
        wr_data.push_back(load_data_o);
        wr_addr.push_back(int'(load_addr_o));
        if (exp_words.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          chk("write_addr", load_addr_o, nwr);
          chk("write_data", load_data_o, exp_words.pop_front());
        end
        nwr++;
      end
      if (dump_en_o) begin
        chk("dump_addr", dump_addr_o, ntx);
        last_den = cyc;
      end
      if (tx_start_o && !prev_start) begin
        chk("tx_byte", tx_byte_o, (ntx < DB) ? ram[ntx] : 8'h00);
        chk("rd_to_start", cyc - last_den, 2);
        if (ntx > 0) chk("interbyte_gap", (cyc - last_done) >= 3, 1);
      end
      if (tx_start_o && tx_done_i) begin
        tx_log.push_back(tx_byte_o);
        ntx++;
        last_done = cyc;
      end
      prev_start = tx_start_o;
    end else prev_start = 1'b0;
  end

  task automatic do_reset();
    rst_i = 1'b1;
    load_en_i = 1'b0;
    dump_en_i = 1'b0;
    rx_done_i = 1'b0;
    #1;
    chk("reset_outputs", {load_we_o, load_addr_o, load_data_o, load_done_o, dump_en_o,
                          dump_addr_o, tx_start_o, tx_byte_o, dump_done_o, busy_o}, 0);
    phase = 0; n_acc = 0; nwr = 0; ntx = 0;
    acc.delete(); exp_words.delete(); wr_data.delete(); wr_addr.delete(); tx_log.delete();
    last_den = -100; last_done = -100;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] b);
    rx_done_i = 1'b1;
    rx_byte_i = b;
    if (phase == 1 && load_en_i && n_acc < LW * 4) begin
      acc.push_back(b);
      n_acc++;
      if (acc.size() == 4) begin
        exp_words.push_back({acc[0], acc[1], acc[2], acc[3]});
        acc.delete();
      end
    end
    @(posedge clk_i); #1;
    rx_done_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic start_load();
    load_en_i = 1'b1;
    idle(1);
    phase = 1;
  endtask

  task automatic start_dump();
    dump_en_i = 1'b1;
    idle(1);
    phase = 2;
  endtask

  task automatic wait_load_done();
    for (int i = 0; i < 300 && !load_done_o; i++) idle(1);
    chk("load_done_reached", load_done_o, 1);
  endtask

  task automatic wait_dump_done(input bit random_en);
    for (int i = 0; i < 3000 && !dump_done_o; i++) begin
      if (random_en) begin
        dump_en_i = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0) begin rx_done_i = 1'b1; rx_byte_i = 8'($urandom); end
      end
      idle(1);
      rx_done_i = 1'b0;
    end
    dump_en_i = 1'b0;
    chk("dump_done_reached", dump_done_o, 1);
    chk("tx_start_low_done", tx_start_o, 0);
    chk("tx_count", ntx, DB);
  endtask

  initial begin
    // Directed load with back-to-back bytes (byte 0xAA lands on the write-pulse cycle), then dump.
    do_reset();
    start_load();
    foreach (ram[i]) ram[i] = 8'h00;
    strobe(8'h11); strobe(8'h22); strobe(8'h33); strobe(8'h44);
    strobe(8'hAA); strobe(8'hBB); strobe(8'hCC); strobe(8'hDD);
    wait_load_done();
    chk("lit_wr_count", wr_data.size(), 2);
    if (wr_data.size() >= 2) begin
      chk("lit_word0", wr_data[0], 32'h11223344);
      chk("lit_addr0", wr_addr[0], 0);
      chk("lit_word1", wr_data[1], 32'hAABBCCDD);
      chk("lit_addr1", wr_addr[1], 1);
    end
    ram[0] = 8'h05; ram[1] = 8'h06; ram[2] = 8'h07;
    rand_delay = 1'b0; tx_delay = 10; spur = 1'b0;
    start_dump();
    wait_dump_done(1'b0);
    chk("lit_tx_len", tx_log.size(), 3);
    if (tx_log.size() == 3) chk("lit_tx_seq", {tx_log[0], tx_log[1], tx_log[2]}, 24'h050607);

    // Pause: bytes offered while load_en_i is low are dropped.
    do_reset();
    start_load();
    strobe(8'h01); strobe(8'h02);
    load_en_i = 1'b0;
    strobe(8'hEE); strobe(8'hEE); strobe(8'hEE);
    load_en_i = 1'b1;
    strobe(8'h03); strobe(8'h04);
    idle(3);
    chk("pause_wr_count", wr_data.size(), 1);
    if (wr_data.size() == 1) chk("pause_word", wr_data[0], 32'h01020304);

    // Both enables in IDLE: load wins, no RAM read during load.
    do_reset();
    load_en_i = 1'b1; dump_en_i = 1'b1;
    idle(1);
    phase = 1;
    for (int i = 0; i < 4; i++) strobe(8'($urandom));
    dump_en_i = 1'b0;
    for (int i = 0; i < 4; i++) strobe(8'($urandom));
    wait_load_done();
    chk("simul_wr_count", nwr, 2);

    // Reset after three bytes: partial word discarded, reload starts at address 0.
    do_reset();
    start_load();
    strobe(8'h91); strobe(8'h92); strobe(8'h93);
    do_reset();
    start_load();
    strobe(8'hA1); strobe(8'hB2); strobe(8'hC3); strobe(8'hD4);
    for (int i = 0; i < 4; i++) strobe(8'($urandom));
    wait_load_done();
    if (wr_data.size() >= 1) begin
      chk("rst_addr0", wr_addr[0], 0);
      chk("rst_word0", wr_data[0], 32'hA1B2C3D4);
    end else chk("rst_wr_count", wr_data.size(), 2);

    // Randomized load/dump sessions with gaps, pauses and stray strobes.
    rand_delay = 1'b1; spur = 1'b1;
    for (int it = 0; it < 15; it++) begin
      do_reset();
      start_load();
      for (int k = 0; k < 600 && n_acc < LW * 4; k++) begin
        if ($urandom_range(0, 5) == 0) load_en_i = ~load_en_i;
        if ($urandom_range(0, 2) != 0) strobe(8'($urandom));
        else idle(1);
      end
      load_en_i = 1'b1;
      strobe(8'($urandom));
      wait_load_done();
      chk("pending_words", exp_words.size(), 0);
      foreach (ram[i]) ram[i] = 8'($urandom);
      start_dump();
      wait_dump_done(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
